// File: rtl/axis_spi_pkg.sv
// Shared types and elaboration helpers for the AXI-Stream SPI master.
package axis_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        HOLD
    } spi_state_t;

    // Width of the tdest field; a single chip select still needs one bit.
    function automatic int csw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int dw, input int div, input int ncs,
                                     input int setup, input int hold);
        return (dw >= 8) && (dw <= 32) && (div >= 2) && ((div % 2) == 0) &&
               (ncs >= 1) && (ncs <= 8) && (setup >= 1) && (hold >= 1);
    endfunction

endpackage

// File: rtl/axis_spi_sck_gen.sv
// Bit-period counter for the SPI master: leading/trailing edge strobes and the SCK level.
module axis_spi_sck_gen #(
    parameter int CLK_DIV = 4,
    parameter bit CPOL    = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic lead,
    output logic trail,
    output logic sck
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign lead  = en && (cnt == CW'(CLK_DIV / 2 - 1));
    assign trail = en && (cnt == CW'(CLK_DIV - 1));

    // Disabling parks SCK at its idle level, so SETUP/HOLD/WAIT never see an edge.
    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            cnt <= '0;
            sck <= CPOL;
        end else begin
            cnt <= trail ? '0 : cnt + 1'b1;
            if (lead || trail)
                sck <= ~sck;
        end
    end

endmodule

// File: rtl/axis_spi_master_mc.sv
// AXI-Stream fed multi-CS SPI master with CS setup/hold timing and tlast-delimited frames.
// Define SPI_READBACK_EN to add MISO capture and the m_axis readback stream.
module axis_spi_master_mc
    import axis_spi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4,
    parameter int NUM_CS     = 4,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [31:0]             s_axis_tdata,
    input  logic [csw(NUM_CS)-1:0]  s_axis_tdest,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
`ifdef SPI_READBACK_EN
    output logic [31:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    input  logic                    MISO,
`endif
    output logic                    MOSI,
    output logic                    SCK,
    output logic [NUM_CS-1:0]       CS_N,
    output logic                    busy
);
    localparam int DW   = DATA_WIDTH;
    localparam int BW   = $clog2(DATA_WIDTH);
    localparam int TMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    if (!params_ok(DATA_WIDTH, CLK_DIV, NUM_CS, CS_SETUP, CS_HOLD)) begin : g_bad_params
        $error("axis_spi_master_mc: illegal parameter set");
    end

    spi_state_t     state;
    logic [BW-1:0]  bit_cnt;
    logic [TW-1:0]  tmr;
    logic [DW-1:0]  tx_sh;
    logic [DW-1:0]  word_in;
    logic [DW-1:0]  load_sh;
    logic           frame_last;
    logic           rst_done;
    logic           lead;
    logic           trail;
    logic           shift_evt;
    logic           word_end;
    logic           accept;
    logic           dest_ok;
    logic           rx_full;
    logic           unused_tdata;

    assign unused_tdata  = ^s_axis_tdata;
    assign word_in       = s_axis_tdata[DW-1:0];
    // CPHA=0 presents the MSB at load time, so the shift register starts one bit ahead.
    assign load_sh       = CPHA ? word_in : (word_in << 1);
    assign shift_evt     = CPHA ? lead : trail;
    assign word_end      = (state == SHIFT) && trail && (bit_cnt == BW'(DW - 1));
    assign s_axis_tready = rst_done && ((state == IDLE) || (state == WAIT)) && !rx_full;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign dest_ok       = 32'(s_axis_tdest) < NUM_CS;
    assign busy          = (state != IDLE);

    axis_spi_sck_gen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_sck_gen (
        .clk    (clk),
        .resetn (resetn),
        .en     (state == SHIFT),
        .lead   (lead),
        .trail  (trail),
        .sck    (SCK)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            CS_N       <= '1;
            MOSI       <= 1'b0;
            tx_sh      <= '0;
            bit_cnt    <= '0;
            tmr        <= '0;
            frame_last <= 1'b0;
            rst_done   <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept && dest_ok) begin
                        state      <= SETUP;
                        CS_N       <= ~(NUM_CS'(1) << s_axis_tdest);
                        tmr        <= '0;
                        frame_last <= s_axis_tlast;
                        tx_sh      <= load_sh;
                        if (!CPHA)
                            MOSI <= word_in[DW-1];
                    end
                end
                SETUP: begin
                    if (tmr == TW'(CS_SETUP - 1))
                        state <= SHIFT;
                    else
                        tmr <= tmr + 1'b1;
                end
                SHIFT: begin
                    if (shift_evt) begin
                        MOSI  <= tx_sh[DW-1];
                        tx_sh <= tx_sh << 1;
                    end
                    if (trail) begin
                        if (word_end) begin
                            bit_cnt <= '0;
                            tmr     <= '0;
                            state   <= frame_last ? HOLD : WAIT;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // Continuation beats keep the frame's chip select; tdest is ignored.
                    if (accept) begin
                        state      <= SHIFT;
                        frame_last <= s_axis_tlast;
                        tx_sh      <= load_sh;
                        if (!CPHA)
                            MOSI <= word_in[DW-1];
                    end
                end
                HOLD: begin
                    if (tmr == TW'(CS_HOLD - 1)) begin
                        state <= IDLE;
                        CS_N  <= '1;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [DW-1:0] rx_sh;
    logic [DW-1:0] rx_next;
    logic          sample;

    assign sample        = CPHA ? trail : lead;
    assign rx_next       = sample ? {rx_sh[DW-2:0], MISO} : rx_sh;
    assign m_axis_tvalid = rx_full;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_sh        <= '0;
            rx_full      <= 1'b0;
            m_axis_tdata <= '0;
        end else begin
            rx_sh <= rx_next;
            if (word_end) begin
                m_axis_tdata <= 32'(rx_next);
                rx_full      <= 1'b1;
            end else if (m_axis_tready) begin
                rx_full <= 1'b0;
            end
        end
    end
`else
    assign rx_full = 1'b0;
`endif

endmodule
